// File: rtl/eae_unit_pkg.sv
// rtl/eae_unit_pkg.sv - EAE shared constants: uc bit indices, operation codes, FSM states
package eae_unit_pkg;

    // Micro-bit positions within IR[7:0]
    localparam int UC_CLA = 7;
    localparam int UC_MQA = 6;
    localparam int UC_SCA = 5;
    localparam int UC_MQL = 4;

    // Operation code held in IR[3:1]
    typedef enum logic [2:0] {
        EAE_NOP = 3'd0,
        EAE_SCL = 3'd1,
        EAE_MUY = 3'd2,
        EAE_DVI = 3'd3,
        EAE_NMI = 3'd4,
        EAE_SHL = 3'd5,
        EAE_ASR = 3'd6,
        EAE_LSR = 3'd7
    } eae_code_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_EXEC = 2'd2,
        ST_DONE = 2'd3
    } eae_state_e;

endpackage

// File: rtl/eae_step.sv
// rtl/eae_step.sv - one combinational EAE iteration on {link,AC,MQ}; divider present only with PDP8_EAE_DIV_EN
module eae_step
    import eae_unit_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  eae_code_e        code,
    input  logic [WIDTH-1:0] operand,
    input  logic             link_in,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    output logic             link_out,
    output logic [WIDTH-1:0] ac_out,
    output logic [WIDTH-1:0] mq_out
);

    logic [WIDTH:0] sum;
`ifdef PDP8_EAE_DIV_EN
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_sub;
`endif

    // Single step selected by code; AC < operand holds throughout a divide, so the
    // trial difference always fits in WIDTH bits when it is taken.
    always_comb begin
        link_out = link_in;
        ac_out   = ac_in;
        mq_out   = mq_in;
        sum      = {1'b0, ac_in} + (mq_in[0] ? {1'b0, operand} : '0);
`ifdef PDP8_EAE_DIV_EN
        rem_sh   = {ac_in, mq_in[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, operand});
        rem_sub  = rem_sh[WIDTH-1:0] - operand;
`endif
        case (code)
            EAE_MUY: begin
                {ac_out, mq_out} = {sum, mq_in[WIDTH-1:1]};
                link_out         = 1'b0;
            end
`ifdef PDP8_EAE_DIV_EN
            EAE_DVI: begin
                ac_out   = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
                mq_out   = {mq_in[WIDTH-2:0], rem_ge};
                link_out = 1'b0;
            end
`endif
            EAE_NMI: begin
                {ac_out, mq_out} = {ac_in[WIDTH-2:0], mq_in, 1'b0};
            end
            EAE_SHL: begin
                {link_out, ac_out, mq_out} = {ac_in, mq_in, 1'b0};
            end
            EAE_ASR: begin
                {ac_out, mq_out} = {ac_in[WIDTH-1], ac_in, mq_in[WIDTH-1:1]};
                link_out         = ac_in[WIDTH-1];
            end
            EAE_LSR: begin
                {ac_out, mq_out} = {1'b0, ac_in, mq_in[WIDTH-1:1]};
                link_out         = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/eae_unit.sv
// rtl/eae_unit.sv - EAE top: FSM, MQ/SC registers, iteration counters; DVI enabled by PDP8_EAE_DIV_EN
module eae_unit
    import eae_unit_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int SCW   = 5
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [7:0]       uc_bits,
    input  logic [WIDTH-1:0] ac_in,
    input  logic             link_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] ac_out,
    output logic             link_out,
    output logic [WIDTH-1:0] mq_out,
    output logic [SCW-1:0]   sc_out,
    output logic             busy,
    output logic             done
);

    localparam int              CNTW     = $clog2(WIDTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
    localparam logic [SCW-1:0]  SC_MAX   = '1;

    eae_state_e       state_q, state_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             link_q, link_d;
    logic [SCW-1:0]   sc_q, sc_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [7:1]       uc_q, uc_d;

    logic [WIDTH-1:0] pre_ac, pre_mq;
    logic [WIDTH-1:0] step_ac, step_mq;
    logic             step_link;
    eae_code_e        code;
    logic             unused_uc0;

    assign unused_uc0 = uc_bits[0];
    assign code       = eae_code_e'(uc_q[3:1]);

    assign ac_out   = ac_q;
    assign link_out = link_q;
    assign mq_out   = mq_q;
    assign sc_out   = sc_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    // Normalised: top two AC bits differ (the 4000/0000 pattern is listed explicitly)
    function automatic logic nmi_stop(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] m);
        nmi_stop = (a[WIDTH-1] != a[WIDTH-2]) ||
                   ((a == {2'b10, {(WIDTH-2){1'b0}}}) && (m == '0));
    endfunction

    // Register micro-ops in order: CLA, then MQA/MQL (both = swap), then SCA
    always_comb begin
        pre_ac = uc_q[UC_CLA] ? '0 : ac_q;
        pre_mq = mq_q;
        if (uc_q[UC_MQA] && uc_q[UC_MQL]) begin
            pre_mq = pre_ac;
            pre_ac = mq_q;
        end else if (uc_q[UC_MQL]) begin
            pre_mq = pre_ac;
            pre_ac = '0;
        end else if (uc_q[UC_MQA]) begin
            pre_ac = pre_ac | mq_q;
        end
        if (uc_q[UC_SCA]) begin
            pre_ac = pre_ac | {{(WIDTH-SCW){1'b0}}, sc_q};
        end
    end

    eae_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .code     (code),
        .operand  (op_q),
        .link_in  (link_q),
        .ac_in    (ac_q),
        .mq_in    (mq_q),
        .link_out (step_link),
        .ac_out   (step_ac),
        .mq_out   (step_mq)
    );

    // Sequencer: capture on start, apply micro-ops in PRE, iterate in EXEC
    always_comb begin
        state_d = state_q;
        ac_d    = ac_q;
        mq_d    = mq_q;
        op_d    = op_q;
        link_d  = link_q;
        sc_d    = sc_q;
        cnt_d   = cnt_q;
        uc_d    = uc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ac_d    = ac_in;
                    link_d  = link_in;
                    op_d    = operand;
                    uc_d    = uc_bits[7:1];
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                ac_d    = pre_ac;
                mq_d    = pre_mq;
                cnt_d   = '0;
                state_d = ST_DONE;
                case (code)
                    EAE_SCL: sc_d = ~op_q[SCW-1:0];
                    EAE_MUY: state_d = ST_EXEC;
`ifdef PDP8_EAE_DIV_EN
                    EAE_DVI: begin
                        if (pre_ac >= op_q) begin
                            link_d = 1'b1;
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
`endif
                    EAE_NMI: begin
                        sc_d = '0;
                        if (!nmi_stop(pre_ac, pre_mq)) begin
                            state_d = ST_EXEC;
                        end
                    end
                    EAE_SHL, EAE_ASR, EAE_LSR: begin
                        sc_d    = op_q[SCW-1:0];
                        state_d = ST_EXEC;
                    end
                    default: ;
                endcase
            end
            ST_EXEC: begin
                ac_d   = step_ac;
                mq_d   = step_mq;
                link_d = step_link;
                case (code)
                    EAE_NMI: begin
                        sc_d = sc_q + 1'b1;
                        if (((sc_q + 1'b1) == SC_MAX) || nmi_stop(step_ac, step_mq)) begin
                            state_d = ST_DONE;
                        end
                    end
                    EAE_SHL, EAE_ASR, EAE_LSR: begin
                        if (sc_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            sc_d = sc_q - 1'b1;
                        end
                    end
                    default: begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything immediately
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            ac_q    <= '0;
            mq_q    <= '0;
            op_q    <= '0;
            link_q  <= 1'b0;
            sc_q    <= '0;
            cnt_q   <= '0;
            uc_q    <= '0;
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            mq_q    <= mq_d;
            op_q    <= op_d;
            link_q  <= link_d;
            sc_q    <= sc_d;
            cnt_q   <= cnt_d;
            uc_q    <= uc_d;
        end
    end

endmodule

// File: tb/tb_eae_unit.sv
// tb/tb_eae_unit.sv - scoreboard bench for eae_unit; DVI expectations follow PDP8_EAE_DIV_EN
module tb_eae_unit;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  uc_bits = '0;
    logic [11:0] ac_in = '0;
    logic        link_in = 1'b0;
    logic [11:0] operand = '0;
    logic [11:0] ac_out, mq_out;
    logic        link_out, busy, done;
    logic [4:0]  sc_out;

    always #5 clk = ~clk;

    eae_unit #(.WIDTH(12), .SCW(5)) dut (
        .clk(clk), .nrst(nrst), .start(start), .uc_bits(uc_bits),
        .ac_in(ac_in), .link_in(link_in), .operand(operand),
        .ac_out(ac_out), .link_out(link_out), .mq_out(mq_out),
        .sc_out(sc_out), .busy(busy), .done(done)
    );

    typedef struct {
        logic [11:0] ac;
        logic [11:0] mq;
        logic        link;
        logic [4:0]  sc;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_issued = 0;
    int          n_done = 0;
    logic [11:0] m_mq = '0;
    logic [4:0]  m_sc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0o expected %0o (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole-operation arithmetic on the architectural registers
    task automatic model(input logic [7:0] uc, input logic [11:0] ac, input logic lk,
                         input logic [11:0] op, output exp_t e);
        logic [11:0] a, m, tmp;
        logic        l;
        logic [4:0]  s;
        logic [23:0] v;
        logic [24:0] w;
        int unsigned vv;
        int          n, lat;
        a = uc[7] ? 12'o0 : ac;
        m = m_mq;
        s = m_sc;
        l = lk;
        lat = 2;
        n = int'(op[4:0]) + 1;
        if (uc[6] && uc[4]) begin
            tmp = a; a = m; m = tmp;
        end else if (uc[4]) begin
            m = a; a = '0;
        end else if (uc[6]) begin
            a = a | m;
        end
        if (uc[5]) a = a | {7'b0, s};
        case (uc[3:1])
            3'd1: s = ~op[4:0];
            3'd2: begin
                v = 24'(m) * 24'(op) + 24'(a);
                {a, m} = v; l = 1'b0; lat = 14;
            end
`ifdef PDP8_EAE_DIV_EN
            3'd3: begin
                if (a >= op) begin
                    l = 1'b1;
                end else begin
                    vv = {8'b0, a, m};
                    m = 12'(vv / {20'b0, op});
                    a = 12'(vv % {20'b0, op});
                    l = 1'b0; lat = 14;
                end
            end
`endif
            3'd4: begin
                s = '0;
                v = {a, m};
                while (!((v[23] != v[22]) || (v == 24'o40000000)) && (s != 5'd31)) begin
                    v = v << 1;
                    s = s + 5'd1;
                end
                {a, m} = v;
                lat = 2 + int'(s);
            end
            3'd5: begin
                w = {l, a, m} << n;
                {l, a, m} = w; s = '0; lat = 2 + n;
            end
            3'd6: begin
                l = a[11];
                v = 24'($signed({a, m}) >>> n);
                {a, m} = v; s = '0; lat = 2 + n;
            end
            3'd7: begin
                v = {a, m} >> n;
                {a, m} = v; l = 1'b0; s = '0; lat = 2 + n;
            end
            default: ;
        endcase
        m_mq = m;
        m_sc = s;
        e.ac = a; e.mq = m; e.link = l; e.sc = s; e.lat = lat; e.t0 = 0;
    endtask

    // Monitor: every done pops one expectation
    always @(negedge clk) begin
        if (nrst && done) begin
            n_done++;
            chk("expectation_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("ac", 32'(ac_out), 32'(mon_e.ac));
                chk("mq", 32'(mq_out), 32'(mon_e.mq));
                chk("link", 32'(link_out), 32'(mon_e.link));
                chk("sc", 32'(sc_out), 32'(mon_e.sc));
                chk("latency", 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
        end
    end

    // Issue one op at a negedge; optionally pulse ignored starts while busy
    task automatic run_op(input logic [7:0] uc, input logic [11:0] ac, input logic lk,
                          input logic [11:0] op, input bit noisy);
        exp_t e;
        uc_bits = uc; ac_in = ac; link_in = lk; operand = op; start = 1'b1;
        model(uc, ac, lk, op, e);
        e.t0 = cyc;
        exp_q.push_back(e);
        n_issued++;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            start   = noisy && ($urandom_range(0, 2) == 0);
            uc_bits = 8'($urandom);
            ac_in   = 12'($urandom);
            link_in = 1'($urandom);
            operand = 12'($urandom);
        end
        start = 1'b0;
        chk("idle_after_op", 32'(busy), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ac", 32'(ac_out), 0);
        chk("rst_mq", 32'(mq_out), 0);
        chk("rst_link", 32'(link_out), 0);
        chk("rst_sc", 32'(sc_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        nrst = 1'b1;
        @(negedge clk);

        run_op(8'o020, 12'o0012, 1'b0, 12'o0000, 1'b0);
        run_op(8'o004, 12'o0000, 1'b1, 12'o0005, 1'b0);
        chk("muy_mq", 32'(mq_out), 32'o0062);
        chk("muy_ac", 32'(ac_out), 0);
        chk("muy_link", 32'(link_out), 0);

        run_op(8'o020, 12'o0144, 1'b0, 12'o0000, 1'b0);
        run_op(8'o006, 12'o0000, 1'b1, 12'o0007, 1'b0);
`ifdef PDP8_EAE_DIV_EN
        chk("dvi_mq", 32'(mq_out), 32'o0016);
        chk("dvi_ac", 32'(ac_out), 32'o0002);
        chk("dvi_link", 32'(link_out), 0);
`else
        chk("dvi_nop_mq", 32'(mq_out), 32'o0144);
        chk("dvi_nop_link", 32'(link_out), 1);
`endif
        run_op(8'o006, 12'o0010, 1'b0, 12'o0007, 1'b0);
`ifdef PDP8_EAE_DIV_EN
        chk("dvi_ovf_link", 32'(link_out), 1);
        chk("dvi_ovf_ac", 32'(ac_out), 32'o0010);
`else
        chk("dvi_nop_link0", 32'(link_out), 0);
`endif

        run_op(8'o020, 12'o0000, 1'b0, 12'o0000, 1'b0);
        run_op(8'o010, 12'o0001, 1'b0, 12'o0000, 1'b0);
        chk("nmi_ac", 32'(ac_out), 32'o2000);
        chk("nmi_sc", 32'(sc_out), 32'o12);
        run_op(8'o010, 12'o4000, 1'b1, 12'o0000, 1'b0);
        chk("nmi_norm_sc", 32'(sc_out), 0);
        run_op(8'o010, 12'o0000, 1'b0, 12'o0000, 1'b0);
        chk("nmi_zero_sc", 32'(sc_out), 32'o37);

        run_op(8'o020, 12'o5670, 1'b0, 12'o0000, 1'b0);
        run_op(8'o120, 12'o1234, 1'b0, 12'o0000, 1'b0);
        chk("swap_ac", 32'(ac_out), 32'o5670);
        chk("swap_mq", 32'(mq_out), 32'o1234);
        run_op(8'o320, 12'o7777, 1'b0, 12'o0000, 1'b0);
        chk("cla_mqa_ac", 32'(ac_out), 32'o1234);

        run_op(8'o020, 12'o4001, 1'b0, 12'o0000, 1'b0);
        run_op(8'o012, 12'o0000, 1'b1, 12'o0002, 1'b0);
        chk("shl_ac", 32'(ac_out), 32'o0004);
        chk("shl_mq", 32'(mq_out), 32'o0010);
        chk("shl_link", 32'(link_out), 0);
        run_op(8'o014, 12'o4000, 1'b0, 12'o0000, 1'b0);
        chk("asr_ac", 32'(ac_out), 32'o6000);
        chk("asr_link", 32'(link_out), 1);
        run_op(8'o016, 12'o7777, 1'b1, 12'o0037, 1'b0);

        run_op(8'o002, 12'o0000, 1'b0, 12'o0025, 1'b0);
        run_op(8'o040, 12'o0000, 1'b0, 12'o0000, 1'b0);
        chk("scl_sca_ac", 32'(ac_out), 32'o0012);

        for (int i = 0; i < 4; i++) begin
            run_op(8'o004, 12'($urandom), 1'b0, 12'($urandom), 1'b1);
        end

        uc_bits = 8'o004; ac_in = 12'o1234; operand = 12'o0777; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ac", 32'(ac_out), 0);
        chk("abort_mq", 32'(mq_out), 0);
        chk("abort_link", 32'(link_out), 0);
        chk("abort_sc", 32'(sc_out), 0);
        m_mq = '0;
        m_sc = '0;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            run_op(8'($urandom),
                   ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 15)) : 12'($urandom),
                   1'($urandom), 12'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        chk("done_count", 32'(n_done), 32'(n_issued));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
